// File: rtl/prores_enc_pkg.sv
// Shared definitions for the ProRes component encode pipeline:
// component identifiers, blocks-per-macroblock constants and the
// small arithmetic helpers used for block counts and byte sizes.
package prores_enc_pkg;

  // Component identifier, in the order the passes run within a slice.
  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_id_e;

  // 8x8 blocks per macroblock (4:2:2: chroma count is per component).
  localparam int unsigned Y_BLOCKS_PER_MB = 4;
  localparam int unsigned C_BLOCKS_PER_MB = 2;

  // Blocks the pipeline must process for one component pass.
  // mb is zero-extended so the product is a plain 32-bit count.
  function automatic logic [31:0] blocks_for_comp(input logic [3:0] mb,
                                                  input comp_id_e id);
    logic [31:0] per_mb;
    per_mb = (id == COMP_Y) ? 32'(Y_BLOCKS_PER_MB) : 32'(C_BLOCKS_PER_MB);
    return {28'd0, mb} * per_mb;
  endfunction

  // ceil(bits/8), saturated to 16 bits. The add is 33 bits wide so an
  // all-ones bit count rounds up instead of wrapping to a tiny value.
  function automatic logic [15:0] bits_to_bytes(input logic [31:0] bits);
    logic [32:0] rounded;
    rounded = ({1'b0, bits} + 33'd7) >> 3;
    if (|rounded[32:16]) begin
      return 16'hFFFF;
    end
    return rounded[15:0];
  endfunction

endpackage

// File: rtl/slice_component_scheduler.sv
// Per-slice controller for the component encode pipeline. Accepts a slice
// descriptor, runs the Y, Cb and Cr passes in turn (start pulse, wait for
// done, capture bit count, flush gap) and reports per-component and total
// slice sizes in bytes for the slice-header writer.
module slice_component_scheduler #(
  parameter int unsigned MAX_MB     = 8,
  parameter int unsigned GAP_CYCLES = 2   // legal 1..15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        slice_valid,
  output logic        slice_ready,
  input  logic [3:0]  mb_num,
  output logic        comp_start,
  output logic [1:0]  comp_id,
  output logic [31:0] comp_block_num,
  input  logic        comp_done,
  input  logic [31:0] comp_bits,
  output logic [15:0] y_bytes,
  output logic [15:0] cb_bytes,
  output logic [15:0] cr_bytes,
  output logic [17:0] slice_bytes,
  output logic        slice_done,
  output logic        busy,
  output logic        cfg_error,
  output logic        spurious_done
);

  import prores_enc_pkg::*;

  localparam logic [3:0] MAX_MB_L = 4'(MAX_MB);
  localparam logic [3:0] GAP_L    = 4'(GAP_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_GAP,
    ST_FINISH
  } sched_state_e;

  sched_state_e state_q, state_d;
  logic [3:0]   mb_q, mb_d;
  comp_id_e     comp_id_q, comp_id_d;
  logic [31:0]  block_num_q, block_num_d;
  logic [3:0]   gap_q, gap_d;
  logic [15:0]  y_bytes_q, y_bytes_d;
  logic [15:0]  cb_bytes_q, cb_bytes_d;
  logic [15:0]  cr_bytes_q, cr_bytes_d;
  logic [17:0]  slice_bytes_q, slice_bytes_d;
  logic         cfg_error_q, cfg_error_d;
  logic         spurious_q, spurious_d;

  logic [15:0]  cap_bytes;
  comp_id_e     next_comp;

  // Outputs that follow directly from the current state.
  assign slice_ready    = (state_q == ST_IDLE);
  assign comp_start     = (state_q == ST_START);
  assign slice_done     = (state_q == ST_FINISH);
  assign busy           = (state_q != ST_IDLE);
  assign comp_id        = comp_id_q;
  assign comp_block_num = block_num_q;
  assign y_bytes        = y_bytes_q;
  assign cb_bytes       = cb_bytes_q;
  assign cr_bytes       = cr_bytes_q;
  assign slice_bytes    = slice_bytes_q;
  assign cfg_error      = cfg_error_q;
  assign spurious_done  = spurious_q;

  // State and datapath registers; reset discards any partial slice.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      mb_q          <= 4'd0;
      comp_id_q     <= COMP_Y;
      block_num_q   <= 32'd0;
      gap_q         <= 4'd0;
      y_bytes_q     <= 16'd0;
      cb_bytes_q    <= 16'd0;
      cr_bytes_q    <= 16'd0;
      slice_bytes_q <= 18'd0;
      cfg_error_q   <= 1'b0;
      spurious_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      mb_q          <= mb_d;
      comp_id_q     <= comp_id_d;
      block_num_q   <= block_num_d;
      gap_q         <= gap_d;
      y_bytes_q     <= y_bytes_d;
      cb_bytes_q    <= cb_bytes_d;
      cr_bytes_q    <= cr_bytes_d;
      slice_bytes_q <= slice_bytes_d;
      cfg_error_q   <= cfg_error_d;
      spurious_q    <= spurious_d;
    end
  end

  // Next-state logic: pass sequencing, gap countdown and size capture.
  always_comb begin
    state_d       = state_q;
    mb_d          = mb_q;
    comp_id_d     = comp_id_q;
    block_num_d   = block_num_q;
    gap_d         = gap_q;
    y_bytes_d     = y_bytes_q;
    cb_bytes_d    = cb_bytes_q;
    cr_bytes_d    = cr_bytes_q;
    slice_bytes_d = slice_bytes_q;
    cfg_error_d   = 1'b0;
    spurious_d    = spurious_q;
    cap_bytes     = bits_to_bytes(comp_bits);
    next_comp     = comp_id_e'(comp_id_q + 2'd1);

    case (state_q)
      ST_IDLE: begin
        if (slice_valid) begin
          if ((mb_num == 4'd0) || (mb_num > MAX_MB_L)) begin
            cfg_error_d = 1'b1;
          end else begin
            mb_d        = mb_num;
            comp_id_d   = COMP_Y;
            block_num_d = blocks_for_comp(mb_num, COMP_Y);
            state_d     = ST_START;
          end
        end
      end

      ST_START: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (comp_done) begin
          // The Y capture restarts the running total for the new slice,
          // so the previous slice's sizes stay visible until this point.
          if (comp_id_q == COMP_Y) begin
            y_bytes_d     = cap_bytes;
            slice_bytes_d = {2'b00, cap_bytes};
          end else if (comp_id_q == COMP_CB) begin
            cb_bytes_d    = cap_bytes;
            slice_bytes_d = slice_bytes_q + {2'b00, cap_bytes};
          end else begin
            cr_bytes_d    = cap_bytes;
            slice_bytes_d = slice_bytes_q + {2'b00, cap_bytes};
          end
          gap_d   = GAP_L;
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_q <= 4'd1) begin
          if (comp_id_q == COMP_CR) begin
            state_d = ST_FINISH;
          end else begin
            comp_id_d   = next_comp;
            block_num_d = blocks_for_comp(mb_q, next_comp);
            state_d     = ST_START;
          end
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A done pulse outside WAIT never contributes to sizing, only flags.
    if (comp_done && (state_q != ST_WAIT)) begin
      spurious_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_slice_component_scheduler.sv
// Directed bench for slice_component_scheduler: full slices, flush-gap
// timing, descriptor rejection, spurious done pulses, mid-slice reset and
// back-to-back slices, each with hand-computed expected values.
module tb_slice_component_scheduler;

  logic        clock;
  logic        reset_n;
  logic        slice_valid;
  logic        slice_ready;
  logic [3:0]  mb_num;
  logic        comp_start;
  logic [1:0]  comp_id;
  logic [31:0] comp_block_num;
  logic        comp_done;
  logic [31:0] comp_bits;
  logic [15:0] y_bytes;
  logic [15:0] cb_bytes;
  logic [15:0] cr_bytes;
  logic [17:0] slice_bytes;
  logic        slice_done;
  logic        busy;
  logic        cfg_error;
  logic        spurious_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sd_cnt  = 0;
  int cfg_cnt = 0;
  int st_cnt  = 0;

  slice_component_scheduler dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .slice_valid    (slice_valid),
    .slice_ready    (slice_ready),
    .mb_num         (mb_num),
    .comp_start     (comp_start),
    .comp_id        (comp_id),
    .comp_block_num (comp_block_num),
    .comp_done      (comp_done),
    .comp_bits      (comp_bits),
    .y_bytes        (y_bytes),
    .cb_bytes       (cb_bytes),
    .cr_bytes       (cr_bytes),
    .slice_bytes    (slice_bytes),
    .slice_done     (slice_done),
    .busy           (busy),
    .cfg_error      (cfg_error),
    .spurious_done  (spurious_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clock) begin
    if (slice_done) sd_cnt  <= sd_cnt + 1;
    if (cfg_error)  cfg_cnt <= cfg_cnt + 1;
    if (comp_start) st_cnt  <= st_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge at which comp_start is high (bounded).
  task automatic wait_start();
    int n;
    n = 0;
    @(negedge clock);
    while (!comp_start && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (!comp_start) check_value("start_timeout", 64'(comp_start), 64'd1);
  endtask

  // Advance to the next negedge at which slice_done is high (bounded).
  task automatic wait_slice_done();
    int n;
    n = 0;
    @(negedge clock);
    while (!slice_done && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (!slice_done) check_value("done_timeout", 64'(slice_done), 64'd1);
  endtask

  // Run one slice acting as the component pipeline. Ends on the negedge
  // where slice_done is observed. lat is the expected number of cycles
  // from this call to the first comp_start.
  task automatic run_slice(input logic [3:0] mb,
                           input logic [31:0] blk_y, input logic [31:0] blk_c,
                           input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2,
                           input logic [15:0] ey, input logic [15:0] ecb,
                           input logic [15:0] ecr, input logic [17:0] esl,
                           input int dly, input int lat, input bit keep,
                           input bit spur, input logic [15:0] y_prev);
    int t0;
    int td;
    logic [31:0] bits [3];
    logic [31:0] blks [3];
    bits[0] = b0; bits[1] = b1; bits[2] = b2;
    blks[0] = blk_y; blks[1] = blk_c; blks[2] = blk_c;
    td = 0;
    slice_valid = 1'b1;
    mb_num      = mb;
    t0          = cyc;
    wait_start();
    check_value("start_latency", 64'(cyc - t0), 64'(lat));
    if (!keep) slice_valid = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (p > 0) begin
        wait_start();
        check_value("gap_to_start", 64'(cyc - td), 64'd3);
      end
      check_value("comp_id_at_start", 64'(comp_id), 64'(p));
      check_value("block_num", 64'(comp_block_num), 64'(blks[p]));
      if (spur && p == 0) begin
        comp_done = 1'b1;
        comp_bits = 32'h0012_3456;
        @(negedge clock);
        comp_done = 1'b0;
        check_value("spur_on_start_flag", 64'(spurious_done), 64'd1);
        check_value("spur_on_start_y_hold", 64'(y_bytes), 64'(y_prev));
        check_value("spur_still_busy", 64'(busy), 64'd1);
        repeat (dly - 1) @(negedge clock);
      end else begin
        repeat (dly) @(negedge clock);
      end
      check_value("comp_id_held", 64'(comp_id), 64'(p));
      comp_done = 1'b1;
      comp_bits = bits[p];
      td        = cyc;
      @(negedge clock);
      comp_done = 1'b0;
    end
    wait_slice_done();
    check_value("done_latency", 64'(cyc - td), 64'd3);
    check_value("y_bytes", 64'(y_bytes), 64'(ey));
    check_value("cb_bytes", 64'(cb_bytes), 64'(ecb));
    check_value("cr_bytes", 64'(cr_bytes), 64'(ecr));
    check_value("slice_bytes", 64'(slice_bytes), 64'(esl));
    $display("slice mb=%0d y=%0d cb=%0d cr=%0d total=%0d",
             mb, y_bytes, cb_bytes, cr_bytes, slice_bytes);
  endtask

  initial begin
    int sd0;
    int cfg0;
    int st0;
    reset_n     = 1'b0;
    slice_valid = 1'b0;
    mb_num      = 4'd0;
    comp_done   = 1'b0;
    comp_bits   = 32'd0;
    repeat (3) @(negedge clock);

    // Reset state.
    check_value("rst_slice_ready", 64'(slice_ready), 64'd1);
    check_value("rst_busy", 64'(busy), 64'd0);
    check_value("rst_comp_start", 64'(comp_start), 64'd0);
    check_value("rst_slice_bytes", 64'(slice_bytes), 64'd0);
    check_value("rst_spurious", 64'(spurious_done), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Full slice: mb=8, bits 1000/500/501 -> 125/63/63, total 251.
    run_slice(4'd8, 32'd32, 32'd16, 32'd1000, 32'd500, 32'd501,
              16'd125, 16'd63, 16'd63, 18'd251, 100, 1, 1'b0, 1'b0, 16'd0);
    repeat (3) @(negedge clock);
    check_value("one_slice_done", 64'(sd_cnt), 64'd1);
    check_value("ready_after_slice", 64'(slice_ready), 64'd1);

    // Rejected descriptors: mb_num 0 then 9.
    cfg0 = cfg_cnt;
    st0  = st_cnt;
    slice_valid = 1'b1;
    mb_num      = 4'd0;
    @(negedge clock);
    check_value("cfg_err_mb0", 64'(cfg_error), 64'd1);
    check_value("cfg_ready_mb0", 64'(slice_ready), 64'd1);
    mb_num = 4'd9;
    @(negedge clock);
    check_value("cfg_err_mb9", 64'(cfg_error), 64'd1);
    check_value("cfg_ready_mb9", 64'(slice_ready), 64'd1);
    slice_valid = 1'b0;
    @(negedge clock);
    check_value("cfg_err_clear", 64'(cfg_error), 64'd0);
    repeat (2) @(negedge clock);
    check_value("cfg_err_count", 64'(cfg_cnt - cfg0), 64'd2);
    check_value("cfg_no_start", 64'(st_cnt - st0), 64'd0);
    check_value("cfg_sizes_hold", 64'(slice_bytes), 64'd251);
    $display("cfg rejects mb=0 and mb=9 done");

    // comp_done on the comp_start cycle; saturating Cr size.
    // bits 8/0/FFFFFFFF -> 1/0/FFFF, total 65536.
    run_slice(4'd1, 32'd4, 32'd2, 32'd8, 32'd0, 32'hFFFF_FFFF,
              16'd1, 16'd0, 16'hFFFF, 18'd65536, 6, 1, 1'b0, 1'b1, 16'd125);
    repeat (2) @(negedge clock);

    // Mid-slice reset during the Cb wait.
    sd0 = sd_cnt;
    slice_valid = 1'b1;
    mb_num      = 4'd2;
    wait_start();
    slice_valid = 1'b0;
    repeat (5) @(negedge clock);
    comp_done = 1'b1;
    comp_bits = 32'd64;
    @(negedge clock);
    comp_done = 1'b0;
    wait_start();
    check_value("rst_mid_cb_id", 64'(comp_id), 64'd1);
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_value("rst_mid_busy", 64'(busy), 64'd0);
    check_value("rst_mid_ready", 64'(slice_ready), 64'd1);
    check_value("rst_mid_y", 64'(y_bytes), 64'd0);
    check_value("rst_mid_cr", 64'(cr_bytes), 64'd0);
    check_value("rst_mid_slice", 64'(slice_bytes), 64'd0);
    check_value("rst_mid_comp_id", 64'(comp_id), 64'd0);
    check_value("rst_mid_blocks", 64'(comp_block_num), 64'd0);
    check_value("rst_mid_spurious", 64'(spurious_done), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(negedge clock);
    check_value("rst_mid_no_done", 64'(sd_cnt - sd0), 64'd0);
    $display("mid-slice reset done");

    // comp_done while idle.
    comp_done = 1'b1;
    comp_bits = 32'd800;
    @(negedge clock);
    comp_done = 1'b0;
    @(negedge clock);
    check_value("spur_idle_flag", 64'(spurious_done), 64'd1);
    check_value("spur_idle_y_hold", 64'(y_bytes), 64'd0);
    check_value("spur_idle_busy", 64'(busy), 64'd0);
    $display("idle comp_done done");

    // Normal slice after reset: mb=3, bits 24/16/8 -> 3/2/1, total 6.
    run_slice(4'd3, 32'd12, 32'd6, 32'd24, 32'd16, 32'd8,
              16'd3, 16'd2, 16'd1, 18'd6, 10, 1, 1'b0, 1'b0, 16'd0);
    repeat (2) @(negedge clock);

    // Back-to-back slices with slice_valid held high, mb=4.
    // First: 80/40/8 -> 10/5/1 = 16. Second: 16/16/16 -> 2/2/2 = 6.
    sd0 = sd_cnt;
    run_slice(4'd4, 32'd16, 32'd8, 32'd80, 32'd40, 32'd8,
              16'd10, 16'd5, 16'd1, 18'd16, 8, 1, 1'b1, 1'b0, 16'd0);
    run_slice(4'd4, 32'd16, 32'd8, 32'd16, 32'd16, 32'd16,
              16'd2, 16'd2, 16'd2, 18'd6, 8, 2, 1'b0, 1'b0, 16'd0);
    repeat (3) @(negedge clock);
    check_value("b2b_done_count", 64'(sd_cnt - sd0), 64'd2);
    check_value("b2b_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
